// File: rtl/ddr5_cmd_sequencer_if.sv
// Request and DRAM command bus bundle for the closed-page DDR5 command sequencer.
// The scheduler side is the master. The sequencer side is the slave.
interface ddr5_cmd_sequencer_if;
  // Request handshake: a request transfers on a cycle where req_valid && req_ready.
  // The master holds req_* stable while req_valid is high and req_ready is low.
  // req_ready is a registered output and does not depend on req_valid.
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_opn;
  logic [2:0]  req_core;
  logic [2:0]  req_bg;
  logic [1:0]  req_ba;
  logic [15:0] req_row;
  logic [9:0]  req_col;

  logic [2:0]  cmd;
  logic [2:0]  cmd_bg;
  logic [1:0]  cmd_ba;
  logic [15:0] cmd_addr;
  logic [2:0]  cmd_core;
  logic        busy;
  logic        err;

  modport master (
    output req_valid, req_opn, req_core, req_bg, req_ba, req_row, req_col,
    input  req_ready, cmd, cmd_bg, cmd_ba, cmd_addr, cmd_core, busy, err
  );

  modport slave (
    input  req_valid, req_opn, req_core, req_bg, req_ba, req_row, req_col,
    output req_ready, cmd, cmd_bg, cmd_ba, cmd_addr, cmd_core, busy, err
  );
endinterface

// File: rtl/ddr5_cmd_sequencer.sv
// Closed-page DDR5 command sequencer: ACT0/ACT1, RD or WR pair, then PRE, all timed in DRAM clocks.
// Every output is a flop computed from the next state. A command therefore appears one cycle after the decision that produces it.
module ddr5_cmd_sequencer #(
  parameter int T_RCD = 39,
  parameter int T_RAS = 76,
  parameter int T_RTP = 18,
  parameter int T_WTP = 48,
  parameter int T_RP  = 39,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  ddr5_cmd_sequencer_if.slave  bus,
  output logic [3:0]           dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE, S_ACT0, S_ACT1, S_WAIT_RCD, S_CAS0, S_CAS1, S_WAIT_PRE, S_PRE, S_WAIT_RP
  } state_e;

  localparam logic [2:0] CMD_NOP = 3'd0, CMD_ACT0 = 3'd1, CMD_ACT1 = 3'd2, CMD_RD0 = 3'd3,
                         CMD_RD1 = 3'd4, CMD_WR0 = 3'd5, CMD_WR1 = 3'd6, CMD_PRE = 3'd7;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   act_cnt_q, act_cnt_d, cas_cnt_q, cas_cnt_d;
  logic [CNT_W-1:0]   act_inc, cas_inc;
  logic [1:0]         opn_q, opn_d;
  logic [2:0]         core_q, core_d, bg_q, bg_d;
  logic [1:0]         ba_q, ba_d;
  logic [15:0]        row_q, row_d;
  logic [9:0]         col_q, col_d;
  logic [2:0]         cmd_q, cmd_d, cmd_bg_q, cmd_bg_d;
  logic [1:0]         cmd_ba_q, cmd_ba_d;
  logic [15:0]        cmd_addr_q, cmd_addr_d;
  logic               busy_q, busy_d, err_q, err_d, ready_q, ready_d;
  logic               hs, fld_load, is_wr, pre_ok;

  always_comb begin
    state_d    = state_q;
    err_d      = 1'b0;
    hs         = bus.req_valid && (state_q == S_IDLE);
    fld_load   = hs && (bus.req_opn != 2'd3);

    // Fields pass straight through on the handshake so ACT0 can carry the row without an extra cycle.
    opn_d  = fld_load ? bus.req_opn  : opn_q;
    core_d = fld_load ? bus.req_core : core_q;
    bg_d   = fld_load ? bus.req_bg   : bg_q;
    ba_d   = fld_load ? bus.req_ba   : ba_q;
    row_d  = fld_load ? bus.req_row  : row_q;
    col_d  = fld_load ? bus.req_col  : col_q;
    is_wr  = (opn_d == 2'd1);

    // act_inc and cas_inc are the counter values in the next cycle, before any reload.
    act_inc = (act_cnt_q == '1) ? act_cnt_q : act_cnt_q + CNT_W'(1);
    cas_inc = (cas_cnt_q == '1) ? cas_cnt_q : cas_cnt_q + CNT_W'(1);
    pre_ok  = (act_inc >= CNT_W'(T_RAS)) &&
              (cas_inc >= (is_wr ? CNT_W'(T_WTP) : CNT_W'(T_RTP)));

    case (state_q)
      S_IDLE: begin
        if (hs) begin
          if (bus.req_opn == 2'd3) err_d   = 1'b1;
          else                     state_d = S_ACT0;
        end
      end
      S_ACT0:                state_d = S_ACT1;
      S_ACT1, S_WAIT_RCD:    state_d = (act_inc >= CNT_W'(T_RCD)) ? S_CAS0 : S_WAIT_RCD;
      S_CAS0:                state_d = S_CAS1;
      S_CAS1, S_WAIT_PRE:    state_d = pre_ok ? S_PRE : S_WAIT_PRE;
      S_PRE, S_WAIT_RP:      state_d = (cas_inc >= CNT_W'(T_RP)) ? S_IDLE : S_WAIT_RP;
      default:               state_d = S_IDLE;
    endcase

    act_cnt_d = (state_d == S_ACT0) ? '0 : act_inc;
    cas_cnt_d = (state_d == S_CAS0 || state_d == S_PRE) ? '0 : cas_inc;

    cmd_d      = CMD_NOP;
    cmd_addr_d = 16'd0;
    case (state_d)
      S_ACT0: begin cmd_d = CMD_ACT0; cmd_addr_d = row_d; end
      S_ACT1: begin cmd_d = CMD_ACT1; cmd_addr_d = row_d; end
      S_CAS0: begin cmd_d = is_wr ? CMD_WR0 : CMD_RD0; cmd_addr_d = {6'b0, col_d}; end
      S_CAS1: begin cmd_d = is_wr ? CMD_WR1 : CMD_RD1; cmd_addr_d = {6'b0, col_d}; end
      S_PRE:        cmd_d = CMD_PRE;
      default:      cmd_d = CMD_NOP;
    endcase
    cmd_bg_d = (cmd_d != CMD_NOP) ? bg_d : 3'd0;
    cmd_ba_d = (cmd_d != CMD_NOP) ? ba_d : 2'd0;
    busy_d   = (state_d != S_IDLE);
    ready_d  = (state_d == S_IDLE);
  end

  // Reset abandons any open sequence without a PRE; the init flow closes the banks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      act_cnt_q  <= '0;
      cas_cnt_q  <= '0;
      opn_q      <= 2'd0;
      core_q     <= 3'd0;
      bg_q       <= 3'd0;
      ba_q       <= 2'd0;
      row_q      <= 16'd0;
      col_q      <= 10'd0;
      cmd_q      <= CMD_NOP;
      cmd_bg_q   <= 3'd0;
      cmd_ba_q   <= 2'd0;
      cmd_addr_q <= 16'd0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      act_cnt_q  <= act_cnt_d;
      cas_cnt_q  <= cas_cnt_d;
      opn_q      <= opn_d;
      core_q     <= core_d;
      bg_q       <= bg_d;
      ba_q       <= ba_d;
      row_q      <= row_d;
      col_q      <= col_d;
      cmd_q      <= cmd_d;
      cmd_bg_q   <= cmd_bg_d;
      cmd_ba_q   <= cmd_ba_d;
      cmd_addr_q <= cmd_addr_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.cmd       = cmd_q;
  assign bus.cmd_bg    = cmd_bg_q;
  assign bus.cmd_ba    = cmd_ba_q;
  assign bus.cmd_addr  = cmd_addr_q;
  assign bus.cmd_core  = core_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_ddr5_cmd_sequencer.sv
// Directed bench for ddr5_cmd_sequencer. Drivers push time-stamped expected events.
// A negedge monitor pops an expected event whenever a DUT shows a command, an err pulse or a rising req_ready.
module tb_ddr5_cmd_sequencer;
  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [3:0] st_a, st_b;
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  bit         mon_en = 1'b0;
  logic       prev_rdy_a, prev_rdy_b;

  // Event layout: {cycle[15:0], kind[1:0], cmd, bg, ba, addr, core}. Kind 0 is a command, 1 is err, 2 is a req_ready rise.
  logic [44:0] exp_a[$];
  logic [44:0] exp_b[$];

  ddr5_cmd_sequencer_if bus_a();
  ddr5_cmd_sequencer_if bus_b();

  ddr5_cmd_sequencer #(.T_RCD(4), .T_RAS(10), .T_RTP(2), .T_WTP(8), .T_RP(3), .CNT_W(8))
    dut_a (.clk(clk), .rst(rst_a), .bus(bus_a), .dbg_state(st_a));
  ddr5_cmd_sequencer #(.T_RCD(4), .T_RAS(4), .T_RTP(2), .T_WTP(8), .T_RP(3), .CNT_W(8))
    dut_b (.clk(clk), .rst(rst_b), .bus(bus_b), .dbg_state(st_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [44:0] ev(input int c, input logic [1:0] k, input logic [2:0] cm,
                                     input logic [2:0] bg, input logic [1:0] ba,
                                     input logic [15:0] ad, input logic [2:0] co);
    logic [31:0] cv;
    cv = c;
    return {cv[15:0], k, cm, bg, ba, ad, co};
  endfunction

  task automatic observe(input int which, input logic [44:0] got);
    logic [44:0] want;
    vectors++;
    if ((which == 0) ? (exp_a.size() == 0) : (exp_b.size() == 0)) begin
      miscompares++;
      $display("FAIL dut%0d unexpected_event got=%h required=none", which, got);
    end else begin
      want = (which == 0) ? exp_a.pop_front() : exp_b.pop_front();
      if (got !== want) begin
        miscompares++;
        $display("FAIL dut%0d event got=%h required=%h", which, got, want);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus_a.cmd !== 3'd0)
        observe(0, ev(cyc, 2'd0, bus_a.cmd, bus_a.cmd_bg, bus_a.cmd_ba, bus_a.cmd_addr, bus_a.cmd_core));
      if (bus_a.err !== 1'b0) observe(0, ev(cyc, 2'd1, 3'd0, 3'd0, 2'd0, 16'd0, 3'd0));
      if (bus_a.req_ready === 1'b1 && prev_rdy_a !== 1'b1)
        observe(0, ev(cyc, 2'd2, 3'd0, 3'd0, 2'd0, 16'd0, 3'd0));
      if (bus_b.cmd !== 3'd0)
        observe(1, ev(cyc, 2'd0, bus_b.cmd, bus_b.cmd_bg, bus_b.cmd_ba, bus_b.cmd_addr, bus_b.cmd_core));
      if (bus_b.err !== 1'b0) observe(1, ev(cyc, 2'd1, 3'd0, 3'd0, 2'd0, 16'd0, 3'd0));
      if (bus_b.req_ready === 1'b1 && prev_rdy_b !== 1'b1)
        observe(1, ev(cyc, 2'd2, 3'd0, 3'd0, 2'd0, 16'd0, 3'd0));
    end
    prev_rdy_a = bus_a.req_ready;
    prev_rdy_b = bus_b.req_ready;
  end

  task automatic push(input int which, input logic [44:0] e);
    if (which == 0) exp_a.push_back(e);
    else            exp_b.push_back(e);
  endtask

  // Full sequence with T_RCD=4: ACT0 t+1, ACT1 t+2, CAS0 t+5, CAS1 t+6. PRE and the req_ready rise are at hand-computed offsets.
  task automatic push_seq(input int which, input int t, input logic [2:0] core, input logic [2:0] bg,
                          input logic [1:0] ba, input logic [15:0] row, input logic [9:0] col,
                          input bit wr, input int pre_off, input int rdy_off);
    push(which, ev(t + 1, 2'd0, 3'd1, bg, ba, row, core));
    push(which, ev(t + 2, 2'd0, 3'd2, bg, ba, row, core));
    push(which, ev(t + 5, 2'd0, wr ? 3'd5 : 3'd3, bg, ba, {6'b0, col}, core));
    push(which, ev(t + 6, 2'd0, wr ? 3'd6 : 3'd4, bg, ba, {6'b0, col}, core));
    push(which, ev(t + pre_off, 2'd0, 3'd7, bg, ba, 16'd0, core));
    push(which, ev(t + rdy_off, 2'd2, 3'd0, 3'd0, 2'd0, 16'd0, 3'd0));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got=%0h required=%0h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  task automatic drive_a(input logic v, input logic [1:0] opn, input logic [2:0] core,
                         input logic [2:0] bg, input logic [1:0] ba,
                         input logic [15:0] row, input logic [9:0] col);
    bus_a.req_valid = v;   bus_a.req_opn = opn; bus_a.req_core = core;
    bus_a.req_bg    = bg;  bus_a.req_ba  = ba;  bus_a.req_row  = row; bus_a.req_col = col;
  endtask

  task automatic wait_ready_a();
    int n;
    n = 0;
    while (bus_a.req_ready !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk("wait_ready_a", {31'd0, bus_a.req_ready}, 32'd1);
  endtask

  initial begin
    int t;
    rst_a = 1'b1;
    rst_b = 1'b1;
    drive_a(1'b0, 2'd0, 3'd0, 3'd0, 2'd0, 16'd0, 10'd0);
    bus_b.req_valid = 1'b0; bus_b.req_opn = 2'd0; bus_b.req_core = 3'd0; bus_b.req_bg = 3'd0;
    bus_b.req_ba    = 2'd0; bus_b.req_row = 16'd0; bus_b.req_col = 10'd0;
    step();
    step();
    chk("rst_cmd",      {29'd0, bus_a.cmd},      32'd0);
    chk("rst_cmd_bg",   {29'd0, bus_a.cmd_bg},   32'd0);
    chk("rst_cmd_ba",   {30'd0, bus_a.cmd_ba},   32'd0);
    chk("rst_cmd_addr", {16'd0, bus_a.cmd_addr}, 32'd0);
    chk("rst_cmd_core", {29'd0, bus_a.cmd_core}, 32'd0);
    chk("rst_busy",     {31'd0, bus_a.busy},     32'd0);
    chk("rst_err",      {31'd0, bus_a.err},      32'd0);
    chk("rst_ready",    {31'd0, bus_a.req_ready}, 32'd1);
    chk("rst_state",    {28'd0, st_a},           32'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    mon_en = 1'b1;
    step();

    // Single read.
    wait_ready_a();
    t = cyc;
    drive_a(1'b1, 2'd0, 3'd3, 3'd5, 2'd2, 16'hABCD, 10'h3F1);
    push_seq(0, t, 3'd3, 3'd5, 2'd2, 16'hABCD, 10'h3F1, 1'b0, 11, 14);
    step();
    drive_a(1'b0, 2'd0, 3'd0, 3'd0, 2'd0, 16'd0, 10'd0);
    chk("rd_busy",  {31'd0, bus_a.busy},      32'd1);
    chk("rd_ready", {31'd0, bus_a.req_ready}, 32'd0);
    repeat (16) step();

    // Single write.
    wait_ready_a();
    t = cyc;
    drive_a(1'b1, 2'd1, 3'd4, 3'd5, 2'd2, 16'hABCD, 10'h3F1);
    push_seq(0, t, 3'd4, 3'd5, 2'd2, 16'hABCD, 10'h3F1, 1'b1, 13, 16);
    step();
    drive_a(1'b0, 2'd0, 3'd0, 3'd0, 2'd0, 16'd0, 10'd0);
    repeat (18) step();

    // Back-to-back reads with req_valid held. The fields change right after the first handshake.
    wait_ready_a();
    t = cyc;
    drive_a(1'b1, 2'd0, 3'd1, 3'd5, 2'd2, 16'hABCD, 10'h3F1);
    push_seq(0, t,      3'd1, 3'd5, 2'd2, 16'hABCD, 10'h3F1, 1'b0, 11, 14);
    push_seq(0, t + 14, 3'd2, 3'd1, 2'd3, 16'h1234, 10'h055, 1'b0, 11, 14);
    step();
    drive_a(1'b1, 2'd0, 3'd2, 3'd1, 2'd3, 16'h1234, 10'h055);
    repeat (13) step();
    chk("b2b_ready_t14", {31'd0, bus_a.req_ready}, 32'd1);
    step();
    drive_a(1'b0, 2'd0, 3'd0, 3'd0, 2'd0, 16'd0, 10'd0);
    repeat (16) step();

    // Illegal request, then an instruction fetch in the next cycle.
    wait_ready_a();
    t = cyc;
    drive_a(1'b1, 2'd3, 3'd5, 3'd5, 2'd2, 16'hABCD, 10'h3F1);
    push(0, ev(t + 1, 2'd1, 3'd0, 3'd0, 2'd0, 16'd0, 3'd0));
    push_seq(0, t + 1, 3'd6, 3'd5, 2'd2, 16'hABCD, 10'h3F1, 1'b0, 11, 14);
    step();
    chk("ill_busy", {31'd0, bus_a.busy}, 32'd0);
    drive_a(1'b1, 2'd2, 3'd6, 3'd5, 2'd2, 16'hABCD, 10'h3F1);
    step();
    drive_a(1'b0, 2'd0, 3'd0, 3'd0, 2'd0, 16'd0, 10'd0);
    repeat (16) step();

    // Two illegal requests back to back.
    wait_ready_a();
    t = cyc;
    drive_a(1'b1, 2'd3, 3'd1, 3'd0, 2'd0, 16'd0, 10'd0);
    push(0, ev(t + 1, 2'd1, 3'd0, 3'd0, 2'd0, 16'd0, 3'd0));
    push(0, ev(t + 2, 2'd1, 3'd0, 3'd0, 2'd0, 16'd0, 3'd0));
    step();
    step();
    drive_a(1'b0, 2'd0, 3'd0, 3'd0, 2'd0, 16'd0, 10'd0);
    step();
    chk("ill2_busy",  {31'd0, bus_a.busy},      32'd0);
    chk("ill2_ready", {31'd0, bus_a.req_ready}, 32'd1);
    step();

    // Reset in WAIT_RCD. The sequence is abandoned with no RD0 and no PRE.
    wait_ready_a();
    t = cyc;
    drive_a(1'b1, 2'd0, 3'd7, 3'd5, 2'd2, 16'hABCD, 10'h3F1);
    push(0, ev(t + 1, 2'd0, 3'd1, 3'd5, 2'd2, 16'hABCD, 3'd7));
    push(0, ev(t + 2, 2'd0, 3'd2, 3'd5, 2'd2, 16'hABCD, 3'd7));
    push(0, ev(t + 4, 2'd2, 3'd0, 3'd0, 2'd0, 16'd0, 3'd0));
    step();
    drive_a(1'b0, 2'd0, 3'd0, 3'd0, 2'd0, 16'd0, 10'd0);
    step();
    step();
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    chk("mrst_cmd",   {29'd0, bus_a.cmd},       32'd0);
    chk("mrst_busy",  {31'd0, bus_a.busy},      32'd0);
    chk("mrst_ready", {31'd0, bus_a.req_ready}, 32'd1);
    chk("mrst_state", {28'd0, st_a},            32'd0);
    chk("mrst_core",  {29'd0, bus_a.cmd_core},  32'd0);
    repeat (20) step();
    t = cyc;
    drive_a(1'b1, 2'd0, 3'd3, 3'd5, 2'd2, 16'hABCD, 10'h3F1);
    push_seq(0, t, 3'd3, 3'd5, 2'd2, 16'hABCD, 10'h3F1, 1'b0, 11, 14);
    step();
    drive_a(1'b0, 2'd0, 3'd0, 3'd0, 2'd0, 16'd0, 10'd0);
    repeat (16) step();

    // Reset coinciding with a handshake. Reset takes priority and no command issues.
    wait_ready_a();
    rst_a = 1'b1;
    drive_a(1'b1, 2'd0, 3'd2, 3'd5, 2'd2, 16'hABCD, 10'h3F1);
    step();
    rst_a = 1'b0;
    drive_a(1'b0, 2'd0, 3'd0, 3'd0, 2'd0, 16'd0, 10'd0);
    chk("rstprio_busy",  {31'd0, bus_a.busy}, 32'd0);
    chk("rstprio_state", {28'd0, st_a},       32'd0);
    repeat (6) step();

    // With T_RAS=4 the read is tRTP-bound: PRE at t+7 and req_ready at t+10.
    t = cyc;
    bus_b.req_valid = 1'b1; bus_b.req_opn = 2'd0; bus_b.req_core = 3'd5; bus_b.req_bg = 3'd5;
    bus_b.req_ba    = 2'd2; bus_b.req_row = 16'hABCD; bus_b.req_col = 10'h3F1;
    push_seq(1, t, 3'd5, 3'd5, 2'd2, 16'hABCD, 10'h3F1, 1'b0, 7, 10);
    step();
    bus_b.req_valid = 1'b0;
    repeat (14) step();

    vectors++;
    if (exp_a.size() != 0) begin
      miscompares += exp_a.size();
      $display("FAIL dut0 missing_events got=%0d required=0", exp_a.size());
    end
    vectors++;
    if (exp_b.size() != 0) begin
      miscompares += exp_b.size();
      $display("FAIL dut1 missing_events got=%0d required=0", exp_b.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
